mul_sequencer: RTL and testbench

- Iterative shift-add multiplier controller for the EX stage.
- Executes mul, mulh and mulhu over 32 cycles instead of one combinational multiply.
- Stalls the pipeline while it runs, then presents the 32-bit result for writeback.
- Sits beside the ALU. The control unit's aluop and the EX operands drive it; its stall output feeds the pipeline stall logic.

---
 rtl/mul_pkg.sv | 23 ++
 rtl/mul_sequencer_if.sv | 26 ++
 rtl/mul_seq_dp.sv | 74 +++++++
 rtl/mul_sequencer.sv | 85 ++++++++
 tb/tb_mul_sequencer.sv | 195 +++++++++++++++++++
 5 files changed

// File: rtl/mul_pkg.sv
// Shared definitions for the iterative multiplier: ALU opcodes handled by the
// sequencer, FSM state type and default widths.
package mul_pkg;

  localparam int unsigned XLEN_DEFAULT  = 32;
  localparam int unsigned CNT_W_DEFAULT = 6;

  localparam logic [3:0] ALU_MUL   = 4'b0101;
  localparam logic [3:0] ALU_MULH  = 4'b0110;
  localparam logic [3:0] ALU_MULHU = 4'b0111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // True for the opcodes this unit executes; everything else belongs to the ALU.
  function automatic logic is_mul_op(input logic [3:0] aluop);
    return (aluop == ALU_MUL) || (aluop == ALU_MULH) || (aluop == ALU_MULHU);
  endfunction

endpackage

// File: rtl/mul_sequencer_if.sv
// EX-stage multiplier bundle.
//   master (pipeline):  drives start, aluop, a, b, flush; observes stall, busy, done, result
//   slave  (sequencer): the reverse
interface mul_sequencer_if #(
  parameter int unsigned XLEN = mul_pkg::XLEN_DEFAULT
);
  logic            start;
  logic [3:0]      aluop;
  logic [XLEN-1:0] a;
  logic [XLEN-1:0] b;
  logic            flush;
  logic            stall;
  logic            busy;
  logic            done;
  logic [XLEN-1:0] result;

  modport master (
    output start, aluop, a, b, flush,
    input  stall, busy, done, result
  );

  modport slave (
    input  start, aluop, a, b, flush,
    output stall, busy, done, result
  );
endinterface

// File: rtl/mul_seq_dp.sv
// Shift-add datapath for the multiplier.
//   clk, rst   clock / async active-high reset
//   load_i     latch operands (magnitudes when signed_i), clear accumulator, cnt = XLEN
//   step_i     one add/shift iteration, cnt decrements
//   finish_i   enables product_o: the post-step product, negated if the signs differed
//   signed_i   operands are signed (mulh)
//   a_i, b_i   multiplicand / multiplier
//   product_o  2*XLEN-bit product, zero unless finish_i
//   last_o     current iteration is the final one
module mul_seq_dp import mul_pkg::*; #(
  parameter int unsigned XLEN  = XLEN_DEFAULT,
  parameter int unsigned CNT_W = CNT_W_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_i,
  input  logic              step_i,
  input  logic              finish_i,
  input  logic              signed_i,
  input  logic [XLEN-1:0]   a_i,
  input  logic [XLEN-1:0]   b_i,
  output logic [2*XLEN-1:0] product_o,
  output logic              last_o
);

  logic [XLEN-1:0]   mcand_q, acc_q, mplier_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              neg_q;

  logic [XLEN-1:0]   a_abs, b_abs;
  logic [XLEN:0]     sum;
  logic [XLEN-1:0]   acc_d, mplier_d;
  logic [2*XLEN-1:0] prod;

  // Magnitudes for the signed case; the most negative value maps to itself,
  // which is its correct unsigned magnitude.
  assign a_abs = a_i[XLEN-1] ? -a_i : a_i;
  assign b_abs = b_i[XLEN-1] ? -b_i : b_i;

  always_comb begin
    sum      = {1'b0, acc_q} + (mplier_q[0] ? {1'b0, mcand_q} : '0);
    // {carry, acc, mplier} >> 1: the carry re-enters at the top of acc.
    acc_d    = sum[XLEN:1];
    mplier_d = {sum[0], mplier_q[XLEN-1:1]};
    prod     = {acc_d, mplier_d};
    product_o = '0;
    if (finish_i) begin
      product_o = neg_q ? -prod : prod;
    end
  end

  assign last_o = (cnt_q == CNT_W'(1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mcand_q  <= '0;
      acc_q    <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
      neg_q    <= 1'b0;
    end else if (load_i) begin
      mcand_q  <= signed_i ? a_abs : a_i;
      mplier_q <= signed_i ? b_abs : b_i;
      neg_q    <= signed_i & (a_i[XLEN-1] ^ b_i[XLEN-1]);
      acc_q    <= '0;
      cnt_q    <= CNT_W'(XLEN);
    end else if (step_i) begin
      acc_q    <= acc_d;
      mplier_q <= mplier_d;
      cnt_q    <= cnt_q - CNT_W'(1);
    end
  end

endmodule

// File: rtl/mul_sequencer.sv
// Iterative multiplier controller for EX (mul / mulh / mulhu, 32 iterations).
//   clk, rst  clock / async active-high reset
//   bus       mul_sequencer_if.slave: start, aluop, a, b, flush in;
//             stall, busy, done, result out
// stall is high from the accept cycle through the last RUN cycle; done pulses
// for one cycle in DONE with result registered on the DONE entry edge.
module mul_sequencer import mul_pkg::*; #(
  parameter int unsigned XLEN  = XLEN_DEFAULT,
  parameter int unsigned CNT_W = CNT_W_DEFAULT
) (
  input logic            clk,
  input logic            rst,
  mul_sequencer_if.slave bus
);

  state_t            state_q;
  logic [3:0]        op_q;
  logic [XLEN-1:0]   result_q;
  logic              done_q;

  logic              accept;
  logic              finish;
  logic              last;
  logic [2*XLEN-1:0] product;
  logic [XLEN-1:0]   result_sel;

  assign accept = (state_q == IDLE) && bus.start && !bus.flush && is_mul_op(bus.aluop);
  assign finish = (state_q == RUN) && last;

  mul_seq_dp #(
    .XLEN  (XLEN),
    .CNT_W (CNT_W)
  ) u_dp (
    .clk       (clk),
    .rst       (rst),
    .load_i    (accept),
    .step_i    (state_q == RUN),
    .finish_i  (finish),
    .signed_i  (bus.aluop == ALU_MULH),
    .a_i       (bus.a),
    .b_i       (bus.b),
    .product_o (product),
    .last_o    (last)
  );

  assign result_sel = (op_q == ALU_MUL) ? product[XLEN-1:0] : product[2*XLEN-1:XLEN];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      op_q     <= '0;
      result_q <= '0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (accept) begin
            state_q <= RUN;
            op_q    <= bus.aluop;
          end
        end
        RUN: begin
          // A flush squashes the multiply outright: no done, result untouched.
          if (bus.flush) begin
            state_q <= IDLE;
          end else if (last) begin
            state_q  <= DONE;
            done_q   <= 1'b1;
            result_q <= result_sel;
          end
        end
        DONE: state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  // Gated by rst so the pipeline never sees a stall during reset.
  assign bus.stall  = !rst && (accept || (state_q == RUN));
  assign bus.busy   = (state_q != IDLE);
  assign bus.done   = done_q;
  assign bus.result = result_q;

endmodule

// File: tb/tb_mul_sequencer.sv
module tb_mul_sequencer;
  import mul_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mul_sequencer_if #(.XLEN(32)) bus ();

  mul_sequencer #(
    .XLEN  (32),
    .CNT_W (6)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int          total = 0;
  int          bad = 0;
  int          done_cnt = 0;
  logic [31:0] expq[$];
  logic [31:0] last_res = '0;

  // Reference: full-width arithmetic products, slice chosen by opcode.
  function automatic logic [31:0] ref_mul(input logic [3:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
    logic [63:0]        pu;
    logic signed [63:0] ps;
    pu = {32'b0, a} * {32'b0, b};
    ps = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
    if (op == ALU_MUL)       return pu[31:0];
    else if (op == ALU_MULH) return ps[63:32];
    else                     return pu[63:32];
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Scoreboard monitor: every done pulse must match the oldest expectation.
  always @(negedge clk) begin
    if (!rst && bus.done) begin
      done_cnt++;
      total++;
      if (expq.size() == 0) begin
        bad++;
        $display("FAIL unexpected_done actual=%0h required=no_done", bus.result);
      end else begin
        logic [31:0] e;
        e = expq.pop_front();
        last_res = e;
        if (bus.result !== e) begin
          bad++;
          $display("FAIL result actual=%0h required=%0h", bus.result, e);
        end
      end
    end
  end

  // Issue one multiply, then follow it to its done pulse checking timing.
  task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    int n;
    int st;
    n = 0;
    @(posedge clk); #1;
    bus.start = 1'b1; bus.aluop = op; bus.a = a; bus.b = b;
    expq.push_back(ref_mul(op, a, b));
    @(negedge clk);
    check("accept_stall", {63'b0, bus.stall}, 64'd1);
    st = bus.stall ? 1 : 0;
    @(posedge clk); #1;
    bus.start = 1'b0;
    do begin
      @(negedge clk);
      n++;
      st += bus.stall ? 1 : 0;
    end while (!bus.done && n < 60);
    check("latency", 64'(n), 64'd33);
    check("stall_cycles", 64'(st), 64'd33);
  endtask

  initial begin
    int d0;
    rst = 1'b1;
    bus.start = 1'b0; bus.aluop = '0; bus.a = '0; bus.b = '0; bus.flush = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_stall", {63'b0, bus.stall}, 64'd0);
    check("rst_busy", {63'b0, bus.busy}, 64'd0);
    check("rst_done", {63'b0, bus.done}, 64'd0);
    check("rst_result", {32'b0, bus.result}, 64'd0);
    rst = 1'b0;

    // Basic mul, result constant, busy afterwards.
    run_op(ALU_MUL, 32'd7, 32'd6);
    check("mul7x6", {32'b0, bus.result}, 64'd42);
    @(negedge clk);
    check("busy_after", {63'b0, bus.busy}, 64'd0);

    // Directed corner operands.
    run_op(ALU_MULH,  32'hFFFF_FFFD, 32'd5);
    run_op(ALU_MUL,   32'hFFFF_FFFD, 32'd5);
    run_op(ALU_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    run_op(ALU_MULH,  32'h8000_0000, 32'h8000_0000);
    run_op(ALU_MULH,  32'h0,         32'h8000_0000);

    // Flush on RUN cycle 10.
    @(posedge clk); #1;
    bus.start = 1'b1; bus.aluop = ALU_MUL; bus.a = 32'd9; bus.b = 32'd9;
    @(posedge clk); #1;
    bus.start = 1'b0;
    d0 = done_cnt;
    repeat (9) @(posedge clk);
    #1 bus.flush = 1'b1;
    @(posedge clk); #1;
    bus.flush = 1'b0;
    @(negedge clk);
    check("flush_stall", {63'b0, bus.stall}, 64'd0);
    check("flush_busy", {63'b0, bus.busy}, 64'd0);
    check("flush_result", {32'b0, bus.result}, {32'b0, last_res});
    repeat (40) @(negedge clk);
    check("flush_no_done", 64'(done_cnt), 64'(d0));

    // Flush together with start in IDLE: no accept.
    @(posedge clk); #1;
    bus.start = 1'b1; bus.flush = 1'b1; bus.aluop = ALU_MUL;
    @(negedge clk);
    check("flush_start_stall", {63'b0, bus.stall}, 64'd0);
    @(posedge clk); #1;
    bus.start = 1'b0; bus.flush = 1'b0;
    @(negedge clk);
    check("flush_start_busy", {63'b0, bus.busy}, 64'd0);

    // Non-multiply opcode is ignored.
    @(posedge clk); #1;
    bus.start = 1'b1; bus.aluop = 4'b0011; bus.a = 32'd3; bus.b = 32'd4;
    @(negedge clk);
    check("badop_stall", {63'b0, bus.stall}, 64'd0);
    @(posedge clk); #1;
    bus.start = 1'b0;
    d0 = done_cnt;
    repeat (40) @(negedge clk);
    check("badop_no_done", 64'(done_cnt), 64'(d0));
    check("badop_busy", {63'b0, bus.busy}, 64'd0);

    // Async reset mid-RUN, away from any clock edge.
    @(posedge clk); #1;
    bus.start = 1'b1; bus.aluop = ALU_MUL; bus.a = 32'd9; bus.b = 32'd9;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (5) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    check("arst_stall", {63'b0, bus.stall}, 64'd0);
    check("arst_busy", {63'b0, bus.busy}, 64'd0);
    check("arst_done", {63'b0, bus.done}, 64'd0);
    check("arst_result", {32'b0, bus.result}, 64'd0);
    expq.delete();
    last_res = '0;
    @(negedge clk);
    rst = 1'b0;
    run_op(ALU_MUL, 32'd123, 32'd456);

    // Back-to-back: second accepted in the IDLE cycle after DONE.
    run_op(ALU_MUL, 32'd3, 32'd4);
    run_op(ALU_MUL, 32'd5, 32'd5);

    // Randomized operations.
    for (int i = 0; i < 16; i++) begin
      logic [3:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      case ($urandom_range(0, 2))
        0:       op = ALU_MUL;
        1:       op = ALU_MULH;
        default: op = ALU_MULHU;
      endcase
      a = $urandom();
      b = $urandom();
      if ($urandom_range(0, 3) == 0) a = (i % 2 == 0) ? 32'h8000_0000 : 32'hFFFF_FFFF;
      if ($urandom_range(0, 5) == 0) b = '0;
      run_op(op, a, b);
    end

    repeat (3) @(negedge clk);
    check("queue_empty", 64'(expq.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
